// File: rtl/keydec_pkg.sv
// Shared definitions for the key event decoder: scancode width, named key codes
// and the decoder FSM state encoding.
package keydec_pkg;

    localparam int SC_W = 9;

    localparam logic [SC_W-1:0] KC_ENTER = 9'h00D;
    localparam logic [SC_W-1:0] KC_SPACE = 9'h020;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MATCH = 2'd1,
        EMIT  = 2'd2,
        ARM   = 2'd3
    } state_e;

endpackage

// File: rtl/key_event_fifo.sv
// Parametrised synchronous FIFO with occupancy count. A push into a full FIFO is
// accepted only when a pop happens in the same cycle; head reads as 0 while empty.
module key_event_fifo #(
    parameter  int WIDTH = 1,
    parameter  int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Depth is a power of two, so the pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = empty ? '0 : mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/key_event_decoder.sv
// Key-release decoder: table lookup of the captured scancode, one-cycle key pulses
// and an event FIFO. Define KEYDEC_SYNC_EN to add a 2-flop synchroniser on released.
//
// state | meaning
// IDLE  | waiting for a rising edge of the release strobe
// MATCH | compare captured code against the key table
// EMIT  | pulse key/unknown output and push a matched index
// ARM   | wait for the release strobe to drop before re-arming
module key_event_decoder
    import keydec_pkg::*;
#(
    parameter  int                          NUM_KEYS   = 2,
    parameter  logic [NUM_KEYS*SC_W-1:0]    KEY_CODES  = {KC_SPACE, KC_ENTER},
    parameter  int                          FIFO_DEPTH = 4,
    localparam int                          IDX_W      = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1,
    localparam int                          CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SC_W-1:0]     scancode,
    input  logic                released,
    output logic [NUM_KEYS-1:0] key_pulse,
    output logic                unknown_pulse,
    output logic                ev_valid,
    output logic [IDX_W-1:0]    ev_key,
    input  logic                ev_ready,
    output logic [CNT_W-1:0]    ev_count,
    output logic                overflow,
    input  logic                ovf_clr
);

    state_e            state_q, state_d;
    logic [SC_W-1:0]   code_q, code_d;
    logic              hit_q, hit_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              rel_s, rel_prev_q;
    logic              ovf_q, ovf_d;
    logic              rise;
    logic              match_hit;
    logic [IDX_W-1:0]  match_idx;
    logic              emit, ev_push, ev_drop;
    logic              fifo_full, fifo_empty;

`ifdef KEYDEC_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[0], released};
    end

    assign rel_s = sync_q[1];
`else
    assign rel_s = released;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rel_prev_q <= 1'b0;
        else     rel_prev_q <= rel_s;
    end

    assign rise = rel_s && !rel_prev_q;

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (code_q == KEY_CODES[i*SC_W +: SC_W]) begin
                match_hit = 1'b1;
                match_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        hit_d   = hit_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    code_d  = scancode;
                    state_d = MATCH;
                end
            end
            MATCH: begin
                hit_d   = match_hit;
                idx_d   = match_idx;
                state_d = EMIT;
            end
            EMIT:    state_d = ARM;
            ARM:     if (!rel_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            code_q  <= '0;
            hit_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            hit_q   <= hit_d;
            idx_q   <= idx_d;
        end
    end

    assign emit          = (state_q == EMIT);
    assign ev_push       = emit && hit_q;
    assign key_pulse     = ev_push ? (NUM_KEYS'(1) << idx_q) : '0;
    assign unknown_pulse = emit && !hit_q;

    // A full FIFO still takes the push if the consumer pops in the same cycle.
    assign ev_drop = ev_push && fifo_full && !ev_ready;
    assign ovf_d   = ev_drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end

    assign overflow = ovf_q;

    key_event_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ev_push),
        .din   (idx_q),
        .pop   (ev_ready),
        .dout  (ev_key),
        .count (ev_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign ev_valid = !fifo_empty;

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed self-checking bench for key_event_decoder (default table: enter, space;
// FIFO depth 4). Inputs change and outputs are sampled on the falling clock edge.
module tb_key_event_decoder;

`ifdef KEYDEC_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic       clk;
    logic       rst;
    logic [8:0] scancode;
    logic       released;
    logic [1:0] key_pulse;
    logic       unknown_pulse;
    logic       ev_valid;
    logic [0:0] ev_key;
    logic       ev_ready;
    logic [2:0] ev_count;
    logic       overflow;
    logic       ovf_clr;

    int n_chk  = 0;
    int n_fail = 0;

    key_event_decoder dut (
        .clk           (clk),
        .rst           (rst),
        .scancode      (scancode),
        .released      (released),
        .key_pulse     (key_pulse),
        .unknown_pulse (unknown_pulse),
        .ev_valid      (ev_valid),
        .ev_key        (ev_key),
        .ev_ready      (ev_ready),
        .ev_count      (ev_count),
        .overflow      (overflow),
        .ovf_clr       (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One release of code; rdy/clr are applied during the EMIT cycle only.
    task automatic press(input logic [8:0] code, input logic [1:0] exp_kp, input logic exp_unk,
                         input logic rdy, input logic clr, input string tag);
        @(negedge clk);
        scancode = code;
        released = 1'b1;
        repeat (SYNC_LAT) @(negedge clk);
        @(negedge clk);
        chk({tag, "_kp_early"}, 32'(key_pulse), 0);
        @(negedge clk);
        chk({tag, "_kp"}, 32'(key_pulse), 32'(exp_kp));
        chk({tag, "_unk"}, 32'(unknown_pulse), 32'(exp_unk));
        released = 1'b0;
        ev_ready = rdy;
        ovf_clr  = clr;
        @(negedge clk);
        ev_ready = 1'b0;
        ovf_clr  = 1'b0;
        chk({tag, "_kp_width"}, 32'(key_pulse), 0);
        chk({tag, "_unk_width"}, 32'(unknown_pulse), 0);
        repeat (SYNC_LAT + 1) @(negedge clk);
    endtask

    task automatic pop(input logic exp_key, input string tag);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(ev_valid), 1);
        chk({tag, "_key"}, 32'(ev_key), 32'(exp_key));
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
    endtask

    initial begin
        int pulses;
        rst      = 1'b1;
        scancode = '0;
        released = 1'b0;
        ev_ready = 1'b0;
        ovf_clr  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_kp", 32'(key_pulse), 0);
        chk("rst_unk", 32'(unknown_pulse), 0);
        chk("rst_valid", 32'(ev_valid), 0);
        chk("rst_key", 32'(ev_key), 0);
        chk("rst_count", 32'(ev_count), 0);
        chk("rst_ovf", 32'(overflow), 0);

        // enter key
        press(9'h00D, 2'b01, 1'b0, 1'b0, 1'b0, "enter");
        chk("enter_valid", 32'(ev_valid), 1);
        chk("enter_count", 32'(ev_count), 1);
        pop(1'b0, "enter_pop");
        chk("enter_count_after", 32'(ev_count), 0);
        chk("enter_valid_after", 32'(ev_valid), 0);

        // space then unknown code
        press(9'h020, 2'b10, 1'b0, 1'b0, 1'b0, "space");
        press(9'h055, 2'b00, 1'b1, 1'b0, 1'b0, "unknown");
        chk("unknown_count", 32'(ev_count), 1);
        chk("unknown_key", 32'(ev_key), 1);
        pop(1'b1, "space_pop");

        // released held high for 20 cycles
        @(negedge clk);
        scancode = 9'h00D;
        released = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (key_pulse != 2'b00) pulses++;
        end
        chk("hold_pulses", pulses, 1);
        chk("hold_count", 32'(ev_count), 1);
        released = 1'b0;
        repeat (SYNC_LAT + 2) @(negedge clk);
        press(9'h020, 2'b10, 1'b0, 1'b0, 1'b0, "rehigh");
        chk("rehigh_count", 32'(ev_count), 2);
        pop(1'b0, "hold_pop0");
        pop(1'b1, "hold_pop1");

        // overflow: five matches, nothing popped
        press(9'h00D, 2'b01, 1'b0, 1'b0, 1'b0, "ovf1");
        press(9'h020, 2'b10, 1'b0, 1'b0, 1'b0, "ovf2");
        press(9'h00D, 2'b01, 1'b0, 1'b0, 1'b0, "ovf3");
        press(9'h020, 2'b10, 1'b0, 1'b0, 1'b0, "ovf4");
        chk("ovf_pre", 32'(overflow), 0);
        press(9'h00D, 2'b01, 1'b0, 1'b0, 1'b0, "ovf5");
        chk("ovf_count", 32'(ev_count), 4);
        chk("ovf_set", 32'(overflow), 1);
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_clr", 32'(overflow), 0);
        pop(1'b0, "ord0");
        pop(1'b1, "ord1");
        pop(1'b0, "ord2");
        pop(1'b1, "ord3");
        chk("ord_empty", 32'(ev_count), 0);

        // full FIFO with a simultaneous pop on the EMIT cycle
        press(9'h00D, 2'b01, 1'b0, 1'b0, 1'b0, "full1");
        press(9'h020, 2'b10, 1'b0, 1'b0, 1'b0, "full2");
        press(9'h00D, 2'b01, 1'b0, 1'b0, 1'b0, "full3");
        press(9'h020, 2'b10, 1'b0, 1'b0, 1'b0, "full4");
        press(9'h020, 2'b10, 1'b0, 1'b1, 1'b0, "fullpop");
        chk("fullpop_count", 32'(ev_count), 4);
        chk("fullpop_ovf", 32'(overflow), 0);

        // overflow set and clear in the same cycle: set wins
        press(9'h00D, 2'b01, 1'b0, 1'b0, 1'b1, "setclr");
        chk("setclr_ovf", 32'(overflow), 1);
        chk("setclr_count", 32'(ev_count), 4);
        pop(1'b1, "fp0");
        pop(1'b0, "fp1");
        pop(1'b1, "fp2");
        pop(1'b1, "fp3");

        // pop while empty is ignored
        @(negedge clk);
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
        chk("empty_pop_count", 32'(ev_count), 0);
        chk("empty_pop_key", 32'(ev_key), 0);
        chk("empty_pop_valid", 32'(ev_valid), 0);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;

        // reset asserted during EMIT with two events queued
        press(9'h00D, 2'b01, 1'b0, 1'b0, 1'b0, "mid1");
        press(9'h020, 2'b10, 1'b0, 1'b0, 1'b0, "mid2");
        chk("mid_count", 32'(ev_count), 2);
        @(negedge clk);
        scancode = 9'h00D;
        released = 1'b1;
        repeat (SYNC_LAT + 2) @(negedge clk);
        chk("mid_emit_kp", 32'(key_pulse), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_kp", 32'(key_pulse), 0);
        chk("mid_rst_unk", 32'(unknown_pulse), 0);
        chk("mid_rst_valid", 32'(ev_valid), 0);
        chk("mid_rst_key", 32'(ev_key), 0);
        chk("mid_rst_count", 32'(ev_count), 0);
        chk("mid_rst_ovf", 32'(overflow), 0);
        released = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        press(9'h00D, 2'b01, 1'b0, 1'b0, 1'b0, "post_rst");
        chk("post_rst_count", 32'(ev_count), 1);
        pop(1'b0, "post_rst_pop");
        chk("post_rst_empty", 32'(ev_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/key_event_decoder.md
Name: key_event_decoder

Overview:
Parametrised, clocked successor to the two-key scancode decoder. Watches the PS/2 receiver's `released` strobe and looks up the captured 9-bit scancode in a parameter-defined key table. On a match it emits a one-cycle one-hot key pulse and queues the key index in a small event FIFO with a valid/ready handshake. Sits between the PS/2 receiver and the calendar control FSM, replacing the edge-clocked enter/space decoder.

Parameters:
NUM_KEYS, 2, number of table entries (1..16)
KEY_CODES, {9'h020, 9'h00D}, packed NUM_KEYS*9-bit table; entry i = bits [9*i+8:9*i]; default entry0 = 0x00D (enter), entry1 = 0x020 (space)
FIFO_DEPTH, 4, event FIFO depth; power of two, 2..16
IDX_W, derived, max(1, $clog2(NUM_KEYS)), key index width (localparam)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
scancode  input  9  code from PS/2 receiver; bit 8 = extended prefix; stable while released is high
released  input  1  key-release indication from receiver; may be asynchronous to clk
key_pulse  output  NUM_KEYS  one-hot, one-cycle pulse of the matched key
unknown_pulse  output  1  one-cycle pulse: release seen, no table match
ev_valid  output  1  FIFO non-empty
ev_key  output  IDX_W  index at FIFO head
ev_ready  input  1  consumer pop; a pop occurs when ev_valid && ev_ready
ev_count  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy
overflow  output  1  sticky: a match was dropped because the FIFO was full
ovf_clr  input  1  clears overflow

Behaviour:
- Reset (asynchronous, active-high): key_pulse = 0, unknown_pulse = 0, ev_valid = 0, ev_key = 0, ev_count = 0, overflow = 0, FSM = IDLE, edge/sync registers = 0. Clock and reset are fixed as stated.
- Edge detect: rel_s = the synchronised released (see Optional Feature). A rise is rel_s == 1 with the previous sample == 0.
- FSM states:
  - IDLE: on a rise, capture scancode into code_q and go to MATCH.
  - MATCH (1 cycle): compare code_q against all entries in parallel. The lowest matching index wins if the table contains duplicates. Register the result and go to EMIT.
  - EMIT (1 cycle): drive key_pulse[idx] = 1 if matched, else unknown_pulse = 1. If matched, push idx. Go to ARM.
  - ARM: wait for rel_s == 0, then go to IDLE. A release held high never retriggers. A new rise is ignored until low has been seen.
- Latency: the rise is sampled in cycle N; key_pulse and the FIFO push occur in cycle N+2. ev_valid rises in cycle N+3 if the FIFO was empty.
- Pulses are exactly one cycle wide. Only one key_pulse bit is set at a time.
- FIFO behaviour:
  - Push when full and no simultaneous pop: drop the event and set overflow.
  - Push and pop in the same cycle while full: both are accepted; count is unchanged and no overflow.
  - Pop when empty: ignored.
  - ev_key holds 0 while the FIFO is empty.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- overflow: ovf_clr clears it. If a set and a clear happen in the same cycle, set wins.
- Reset mid-operation (any state): all state and outputs return to reset values and FIFO contents are discarded.

Optional Feature:
Macro KEYDEC_SYNC_EN.
- Defined: released passes through a 2-flop synchroniser (reset to 0) before edge detect. Total latency becomes N+4 from the raw rise.
- Undefined: released is assumed synchronous to clk and feeds edge detect directly; the latencies above apply.

Decomposition:
- Shared package keydec_pkg holds:
  - FSM state enum: IDLE, MATCH, EMIT, ARM.
  - Scancode width constant SC_W = 9.
  - Named code constants KC_ENTER = 9'h00D and KC_SPACE = 9'h020.
- One natural sub-module: key_event_fifo, a parametrised synchronous FIFO (width IDX_W, depth FIFO_DEPTH) with count, full/empty and a same-cycle push/pop rule. It is reused by later calendar input blocks.

Test Plan:
- Reset mid-stream: assert rst during EMIT with 2 events queued → all outputs 0, ev_count = 0; the next release decodes normally.
- scancode = 0x00D, released 0→1 → key_pulse = 2'b01 for exactly 1 cycle at N+2; ev_valid = 1 with ev_key = 0; pop → ev_count = 0.
- scancode = 0x020, then 0x055 → key_pulse = 2'b10, then unknown_pulse = 1 with no push; ev_count = 1.
- released held high 20 cycles → exactly one event; a glitch-free low followed by a high yields a second event.
- 5 matches with ev_ready = 0 and FIFO_DEPTH = 4 → ev_count = 4, overflow = 1. FIFO order on pop is preserved: 0,1,0,1. ovf_clr → overflow = 0.
- FIFO full with ev_ready = 1 on the EMIT cycle → count stays 4, overflow stays 0; the popped head is replaced at the tail.
